// File: rtl/peripheral_spram_arbiter_if.sv
// Requester and SRAM-side signal bundle for peripheral_spram_arbiter.
// The slave modport is the arbiter view; the master modport drives requests and SRAM read data.
interface peripheral_spram_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*BE_WIDTH-1:0]   be_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            lock_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          req_o;
    logic                          we_o;
    logic [ADDR_WIDTH-1:0]         addr_o;
    logic [BE_WIDTH-1:0]           be_o;
    logic [DATA_WIDTH-1:0]         data_o;
    logic [DATA_WIDTH-1:0]         data_i;

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i, lock_i, data_i,
        output gnt_o, rvalid_o, rdata_o, req_o, we_o, addr_o, be_o, data_o
    );

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i, lock_i, data_i,
        input  gnt_o, rvalid_o, rdata_o, req_o, we_o, addr_o, be_o, data_o
    );
endinterface

// File: rtl/peripheral_spram_arbiter.sv
// Round-robin arbiter sharing one registered single-port SRAM port among NUM_REQ requesters.
// Define PERIPHERAL_SPRAM_ARB_LOCK_EN to let the last-granted requester hold the port via lock_i.
module peripheral_spram_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    peripheral_spram_arbiter_if.slave   bus
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_WIDTH-1:0]                ptr;
    logic [IDX_WIDTH-1:0]                gnt_idx_c;
    logic                                gnt_any_c;
    logic                                locked_c;
    logic [NUM_REQ-1:0]                  gnt_c;
    logic                                sel_we_c;
    logic [ADDR_WIDTH-1:0]               sel_addr_c;
    logic [BE_WIDTH-1:0]                 sel_be_c;
    logic [DATA_WIDTH-1:0]               sel_data_c;
    logic                                sram_req;
    logic                                sram_we;
    logic [ADDR_WIDTH-1:0]               sram_addr;
    logic [BE_WIDTH-1:0]                 sram_be;
    logic [DATA_WIDTH-1:0]               sram_data;
    logic [NUM_REQ-1:0]                  iss_id;
    logic [RD_LATENCY-1:0][NUM_REQ-1:0]  tag;

`ifdef PERIPHERAL_SPRAM_ARB_LOCK_EN
    logic [IDX_WIDTH-1:0]                last_idx;
    logic                                last_vld;
`else
    logic                                unused_lock;
    assign unused_lock = ^bus.lock_i;
`endif

    // Index arithmetic wraps at NUM_REQ-1, not at a power of two.
    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx,
                                                      input int unsigned step);
        int unsigned sum;
        sum = 32'(idx) + step;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IDX_WIDTH'(sum);
    endfunction

    // Grant selection: lock holder first (when enabled), else search from ptr.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        locked_c  = 1'b0;
`ifdef PERIPHERAL_SPRAM_ARB_LOCK_EN
        if (last_vld && bus.lock_i[last_idx] && bus.req_i[last_idx]) begin
            gnt_any_c = 1'b1;
            gnt_idx_c = last_idx;
            locked_c  = 1'b1;
        end
`endif
        for (int unsigned o = 0; o < NUM_REQ; o++) begin
            if (!gnt_any_c && bus.req_i[wrap_inc(ptr, o)]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = wrap_inc(ptr, o);
            end
        end
    end

    always_comb begin
        gnt_c = '0;
        if (gnt_any_c && !rst_i) gnt_c[gnt_idx_c] = 1'b1;
    end

    // One-hot AND-OR mux of the granted requester's fields.
    always_comb begin
        sel_we_c   = 1'b0;
        sel_addr_c = '0;
        sel_be_c   = '0;
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_we_c   = bus.we_i[i];
                sel_addr_c = bus.addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_be_c   = bus.be_i[i*BE_WIDTH +: BE_WIDTH];
                sel_data_c = bus.wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // SRAM issue register, pointer and read-tag pipeline; an all-zero tag is an empty slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr       <= '0;
            sram_req  <= 1'b0;
            sram_we   <= 1'b0;
            sram_addr <= '0;
            sram_be   <= '0;
            sram_data <= '0;
            iss_id    <= '0;
            tag       <= '0;
`ifdef PERIPHERAL_SPRAM_ARB_LOCK_EN
            last_idx  <= '0;
            last_vld  <= 1'b0;
`endif
        end else begin
            sram_req <= gnt_any_c;
            iss_id   <= gnt_c;
            if (gnt_any_c) begin
                sram_we   <= sel_we_c;
                sram_addr <= sel_addr_c;
                sram_be   <= sel_be_c;
                sram_data <= sel_data_c;
                if (!locked_c) ptr <= wrap_inc(gnt_idx_c, 1);
            end
`ifdef PERIPHERAL_SPRAM_ARB_LOCK_EN
            if (gnt_any_c) begin
                last_idx <= gnt_idx_c;
                last_vld <= 1'b1;
            end
`endif
            tag[0] <= (sram_req && !sram_we) ? iss_id : '0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
        end
    end

    assign bus.gnt_o    = gnt_c;
    assign bus.rvalid_o = tag[RD_LATENCY-1];
    assign bus.rdata_o  = bus.data_i;
    assign bus.req_o    = sram_req;
    assign bus.we_o     = sram_we;
    assign bus.addr_o   = sram_addr;
    assign bus.be_o     = sram_be;
    assign bus.data_o   = sram_data;
endmodule
